ldpc_varnode: RTL and testbench

Variable-node update for the min-sum LDPC decoder. It is the counterpart of ldpc_minsigner: it consumes the check-to-variable messages that the check side produces, and emits the variable-to-check extrinsic messages that feed the check side.
- Per variable node: one channel LLR plus a serial stream of d incoming check messages.
- Accumulates total = channel + sum(messages).
- Streams back d extrinsic messages sat(total - msg_k), plus the hard decision.

---
 rtl/ldpc_pkg.sv | 28 ++
 rtl/ldpc_llr_sat.sv | 23 ++
 rtl/ldpc_varnode.sv | 117 +++++++++++
 tb/tb_ldpc_varnode.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the min-sum LDPC decoder datapath.
// Used by both the check-node (minsigner) and variable-node blocks.
package ldpc_pkg;

  localparam int LLR_W = 8;

  typedef logic signed [LLR_W-1:0] llr_t;

  // Clamping is symmetric, so the most negative code is never produced.
  localparam int LLR_MAX     = (2 ** (LLR_W - 1)) - 1;
  localparam int LLR_MIN_SYM = -LLR_MAX;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  function automatic llr_t sat_llr(input logic signed [31:0] acc);
    if (acc > LLR_MAX) begin
      return llr_t'(LLR_MAX);
    end else if (acc < LLR_MIN_SYM) begin
      return llr_t'(LLR_MIN_SYM);
    end
    return llr_t'(acc);
  endfunction

endpackage

// File: rtl/ldpc_llr_sat.sv
// Combinational symmetric saturator: narrows a wide signed sum to an LLR,
// clamping to +/-(2^(LLR_W-1)-1).
module ldpc_llr_sat #(
  parameter int ACC_W = 12,
  parameter int LLR_W = 8
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [LLR_W-1:0] o_llr
);

  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((2 ** (LLR_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

  always_comb begin
    o_llr = i_acc[LLR_W-1:0];
    if (i_acc > POS_LIM) begin
      o_llr = POS_LIM[LLR_W-1:0];
    end else if (i_acc < NEG_LIM) begin
      o_llr = NEG_LIM[LLR_W-1:0];
    end
  end

endmodule

// File: rtl/ldpc_varnode.sv
// Min-sum LDPC variable-node update: accumulates channel + check messages, then
// streams back saturated extrinsics (total - msg_k) with the hard decision.
module ldpc_varnode #(
  parameter int LLR_W   = 8,
  parameter int MAX_DEG = 8,
  parameter int ACC_W   = 12
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [LLR_W-1:0] i_chan_llr,
  input  logic signed [LLR_W-1:0] i_data,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic signed [LLR_W-1:0] o_data,
  output logic                    o_hard,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_overflow
);
  import ldpc_pkg::*;

  localparam int CNT_W = $clog2(MAX_DEG + 1);
  localparam int IDX_W = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        count, idx, idx_nxt;
  logic signed [ACC_W-1:0] acc, acc_in, acc_sel;
  logic signed [LLR_W-1:0] buf_q [2**IDX_W];
  logic signed [LLR_W-1:0] msg_sel, sat_out;
  logic signed [ACC_W:0]   diff;
  logic                    in_fire, out_fire, at_cap, beat_last, load_first;

  assign o_ready    = (state != EMIT);
  assign in_fire    = i_valid && o_ready;
  assign out_fire   = o_valid && i_ready;
  assign at_cap     = (count == CNT_W'(MAX_DEG - 1));
  assign beat_last  = i_last || at_cap;
  assign load_first = in_fire && beat_last;
  assign idx_nxt    = idx + CNT_W'(1);
  assign acc_in     = ((state == IDLE) ? ACC_W'(i_chan_llr) : acc) + ACC_W'(i_data);

  // The first extrinsic is formed from the in-flight total and message so it
  // can be registered on the same edge that accepts the closing beat.
  always_comb begin
    acc_sel = acc;
    msg_sel = buf_q[idx_nxt[IDX_W-1:0]];
    if (load_first) begin
      acc_sel = acc_in;
      msg_sel = (state == IDLE) ? i_data : buf_q[0];
    end
  end

  assign diff = (ACC_W + 1)'(acc_sel) - (ACC_W + 1)'(msg_sel);

  ldpc_llr_sat #(
    .ACC_W(ACC_W + 1),
    .LLR_W(LLR_W)
  ) u_sat (
    .i_acc(diff),
    .o_llr(sat_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (in_fire) state_nxt = beat_last ? EMIT : ACCUM;
      EMIT:        if (out_fire && o_last) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clock) begin
    if (in_fire) buf_q[count[IDX_W-1:0]] <= i_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count      <= '0;
      idx        <= '0;
      acc        <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_hard     <= 1'b0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else if (in_fire) begin
      acc   <= acc_in;
      count <= count + CNT_W'(1);
      if (at_cap && !i_last) o_overflow <= 1'b1;
      if (beat_last) begin
        idx     <= '0;
        o_valid <= 1'b1;
        o_data  <= sat_out;
        o_hard  <= acc_in[ACC_W-1];
        o_last  <= (count == '0);
      end
    end else if (out_fire) begin
      if (o_last) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
        count   <= '0;
      end else begin
        idx    <= idx_nxt;
        o_data <= sat_out;
        o_last <= (idx_nxt == count - CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_ldpc_varnode.sv
// Self-checking bench for ldpc_varnode: a queue-based node model predicts every
// output beat, backed by directed nodes with hand-computed expectations.
module tb_ldpc_varnode;

  localparam int LLR_W   = 8;
  localparam int MAX_DEG = 8;
  localparam int ACC_W   = 12;

  logic                    i_clock, i_reset, i_valid, i_last, i_ready;
  logic signed [LLR_W-1:0] i_chan_llr, i_data, o_data;
  logic                    o_ready, o_hard, o_last, o_valid, o_overflow;

  typedef struct {
    int data;
    int hard;
    int last;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t mb;
  int    cur_msgs[$];
  int    cur_chan, tot;
  bit    m_ovf;

  int n_total, n_bad;
  int held22, stall_left;
  bit stall_arm, rand_ready, gap_mode;
  int stim[16];
  int want[16];

  ldpc_varnode #(
    .LLR_W(LLR_W),
    .MAX_DEG(MAX_DEG),
    .ACC_W(ACC_W)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_chan_llr(i_chan_llr),
    .i_data(i_data),
    .i_valid(i_valid),
    .i_last(i_last),
    .o_ready(o_ready),
    .o_data(o_data),
    .o_hard(o_hard),
    .o_last(o_last),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_overflow(o_overflow)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic int sat_model(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Reference model: collects each node, then queues the beats it must emit.
  always @(negedge i_clock) begin
    if (i_reset) begin
      exp_q.delete();
      cur_msgs.delete();
      m_ovf = 1'b0;
    end else begin
      checkOutput("valid_vs_model", int'(o_valid), int'(exp_q.size() != 0));
      checkOutput("ready_vs_model", int'(o_ready), int'(exp_q.size() == 0));
      checkOutput("overflow_flag", int'(o_overflow), int'(m_ovf));
      if (o_valid && exp_q.size() != 0) begin
        checkOutput("beat_data", int'(o_data), exp_q[0].data);
        checkOutput("beat_hard", int'(o_hard), exp_q[0].hard);
        checkOutput("beat_last", int'(o_last), exp_q[0].last);
        if (!i_ready && o_data == 22) held22++;
        if (i_ready) begin
          mb.data = int'(o_data);
          mb.hard = int'(o_hard);
          mb.last = int'(o_last);
          got_q.push_back(mb);
          void'(exp_q.pop_front());
        end
      end
      if (i_valid && o_ready) begin
        if (cur_msgs.size() == 0) cur_chan = int'(i_chan_llr);
        cur_msgs.push_back(int'(i_data));
        if (i_last || cur_msgs.size() == MAX_DEG) begin
          if (!i_last) m_ovf = 1'b1;
          tot = cur_chan;
          foreach (cur_msgs[k]) tot += cur_msgs[k];
          foreach (cur_msgs[k]) begin
            mb.data = sat_model(tot - cur_msgs[k]);
            mb.hard = int'(tot < 0);
            mb.last = int'(k == cur_msgs.size() - 1);
            exp_q.push_back(mb);
          end
          cur_msgs.delete();
        end
      end
    end
  end

  // Downstream back-pressure: scripted stall on the value 22, or random.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clock);
      #1;
      if (stall_left > 0) begin
        i_ready = 1'b0;
        stall_left--;
      end else if (stall_arm && o_valid && o_data == 22) begin
        i_ready    = 1'b0;
        stall_left = 2;
        stall_arm  = 1'b0;
      end else if (rand_ready) begin
        i_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input int chan, input int n, input bit use_last);
    int  waited;
    bit  hs;
    for (int i = 0; i < n; i++) begin
      if (gap_mode) begin
        i_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge i_clock);
          #1;
        end
      end
      i_valid    = 1'b1;
      i_data     = LLR_W'(stim[i]);
      i_chan_llr = (i == 0) ? LLR_W'(chan) : LLR_W'($urandom);
      i_last     = use_last && (i == n - 1);
      waited     = 0;
      do begin
        hs = o_ready;
        @(posedge i_clock);
        #1;
        waited++;
      end while (!hs && waited < 300);
      if (!hs) checkOutput("accept_timeout", 0, 1);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || cur_msgs.size() != 0) && w < 2000) begin
      @(posedge i_clock);
      #1;
      w++;
    end
    checkOutput("drain_done", int'(exp_q.size() != 0 || cur_msgs.size() != 0), 0);
  endtask

  task automatic checkGot(input int n, input int len, input int hard);
    checkOutput("got_beat_count", got_q.size(), n);
    if (got_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        checkOutput("got_data", got_q[i].data, want[i]);
        checkOutput("got_hard", got_q[i].hard, hard);
        checkOutput("got_last", got_q[i].last, int'((i % len) == len - 1));
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    held22 = 0;
    stall_left = 0;
    stall_arm = 1'b0;
    rand_ready = 1'b0;
    gap_mode = 1'b0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    i_data = '0;
    i_chan_llr = '0;
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b0;

    checkOutput("reset_valid", int'(o_valid), 0);
    checkOutput("reset_data", int'(o_data), 0);
    checkOutput("reset_hard", int'(o_hard), 0);
    checkOutput("reset_last", int'(o_last), 0);
    checkOutput("reset_overflow", int'(o_overflow), 0);
    checkOutput("reset_ready", int'(o_ready), 1);

    repeat (1000) begin
      @(posedge i_clock);
      #1;
      checkOutput("idle_outputs_zero",
                  int'(o_valid || o_hard || o_last || o_overflow || o_data != 0), 0);
      checkOutput("idle_ready", int'(o_ready), 1);
    end

    // Basic node: total 19, extrinsics 14, 22, 12.
    stim[0] = 5; stim[1] = -3; stim[2] = 7;
    want[0] = 14; want[1] = 22; want[2] = 12;
    got_q.delete();
    applyStimulus(10, 3, 1);
    checkOutput("first_valid_latency", int'(o_valid), 1);
    waitDrain();
    checkGot(3, 3, 0);

    // Saturation in both directions.
    stim[0] = 100; stim[1] = 100;
    want[0] = 127; want[1] = 127;
    got_q.delete();
    applyStimulus(100, 2, 1);
    waitDrain();
    checkGot(2, 2, 0);
    stim[0] = -128; stim[1] = -128;
    want[0] = -127; want[1] = -127;
    got_q.delete();
    applyStimulus(-128, 2, 1);
    waitDrain();
    checkGot(2, 2, 1);

    // Back-pressure on the second beat, then a back-to-back node.
    stim[0] = 5; stim[1] = -3; stim[2] = 7;
    for (int i = 0; i < 6; i++) want[i] = (i % 3 == 0) ? 14 : ((i % 3 == 1) ? 22 : 12);
    got_q.delete();
    held22 = 0;
    stall_arm = 1'b1;
    applyStimulus(10, 3, 1);
    applyStimulus(10, 3, 1);
    waitDrain();
    checkOutput("stall_cycles_held_22", held22, 3);
    checkGot(6, 3, 0);

    // Overflow: eight messages with no closing flag.
    for (int i = 0; i < 8; i++) begin
      stim[i] = 1;
      want[i] = 7;
    end
    got_q.delete();
    applyStimulus(0, 8, 0);
    waitDrain();
    checkGot(8, 8, 0);
    checkOutput("overflow_set", int'(o_overflow), 1);
    stim[0] = 5; stim[1] = -3; stim[2] = 7;
    applyStimulus(10, 3, 1);
    waitDrain();
    checkOutput("overflow_sticky", int'(o_overflow), 1);

    // Randomized nodes under random gaps and back-pressure.
    rand_ready = 1'b1;
    gap_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int deg;
      bit use_last;
      deg = $urandom_range(1, MAX_DEG);
      for (int i = 0; i < deg; i++) stim[i] = int'($urandom_range(0, 255)) - 128;
      use_last = (deg < MAX_DEG) ? 1'b1 : bit'($urandom_range(0, 1));
      applyStimulus(int'($urandom_range(0, 255)) - 128, deg, use_last);
    end
    waitDrain();
    rand_ready = 1'b0;
    gap_mode = 1'b0;
    @(posedge i_clock);
    #1;

    // Reset in the middle of emitting a node.
    stim[0] = 5; stim[1] = -3; stim[2] = 7;
    got_q.delete();
    applyStimulus(10, 3, 1);
    begin
      int w;
      w = 0;
      while (got_q.size() < 1 && w < 100) begin
        @(posedge i_clock);
        #1;
        w++;
      end
      checkOutput("first_beat_seen", int'(got_q.size() >= 1), 1);
    end
    i_reset = 1'b1;
    #1;
    checkOutput("valid_drop_on_reset", int'(o_valid), 0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    checkOutput("post_reset_valid", int'(o_valid), 0);
    checkOutput("post_reset_ready", int'(o_ready), 1);
    checkOutput("post_reset_overflow", int'(o_overflow), 0);

    // Total is -1 + 4 = 3, so the extrinsic is -1 and the decision is 0.
    stim[0] = 4;
    want[0] = -1;
    got_q.delete();
    applyStimulus(-1, 1, 1);
    waitDrain();
    checkGot(1, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
